pc_sequencer: RTL and testbench

- Parametrised successor to the single-cycle program counter.
- Holds a word-aligned PC and selects the next PC from several sources in priority order: exception, ERET, JR, J/JAL, taken branch, sequential.
- Adds a stall input, an exception/EPC path, and a small return-address stack (RAS) for call/return tracking.
- Sits between the control/ALU outputs and the instruction memory address port.

---
 rtl/mips_pkg.sv | 10 +
 rtl/pc_ras.sv | 47 ++++
 rtl/pc_sequencer.sv | 85 ++++++++
 tb/tb_pc_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS instruction-fetch front end.
package mips_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;
  localparam int RAS_DEPTH_DEF = 4;
  typedef enum logic [2:0] {
    PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_ERET, PCSRC_EXC
  } pc_src_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arstn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_replace,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [PW:0] cnt_q, cnt_d;
  logic psh, rep, pop, wr_en;
  always_comb begin
    top_idx = ptr_q - 1'b1;
    o_empty = cnt_q == '0;
    o_full = cnt_q == (PW+1)'(RAS_DEPTH);
    o_top = o_empty ? '0 : mem_q[top_idx];
    // a replace on an empty stack has nothing to replace, so it becomes a push
    psh = i_push | (i_replace & o_empty);
    rep = i_replace & !o_empty;
    pop = i_pop & !o_empty;
    wr_en = psh | rep;
    wr_idx = rep ? top_idx : ptr_q;
    ptr_d = psh ? ptr_q + 1'b1 : pop ? top_idx : ptr_q;
    cnt_d = psh ? (o_full ? cnt_q : cnt_q + 1'b1) : pop ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_idx] <= i_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: word-aligned program counter with prioritised next-PC select,
// exception/EPC path and return-address stack tracking calls and returns.
module pc_sequencer import mips_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEF),
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_arstn,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [15:0]      i_branch_offset,
  input  logic             i_jump,
  input  logic [25:0]      i_jump_index,
  input  logic             i_jr,
  input  logic [WIDTH-1:0] i_jr_target,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic             i_exception,
  input  logic             i_eret,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_epc,
  output logic [WIDTH-1:0] o_ras_top,
  output logic             o_ras_empty,
  output logic             o_ras_full,
  output logic             o_ras_mismatch,
  output logic             o_misaligned
);
  logic [WIDTH-3:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d, next_pc, j_tgt, br_tgt;
  logic mismatch_q, mismatch_d, misaligned_q, misaligned_d;
  logic jr_bad, exc, adv, hold, push, pop, replace;
  pc_src_e src;
  always_comb begin
    o_pc = {pc_q, 2'b00};
    o_pc_plus4 = o_pc + WIDTH'(4);
    jr_bad = i_jr & (i_jr_target[1:0] != 2'b00);
    exc = i_exception | jr_bad;
    hold = i_stall & !exc;
    adv = !exc & !i_stall;
    j_tgt = {o_pc_plus4[WIDTH-1:28], i_jump_index, 2'b00};
    br_tgt = o_pc_plus4 + {{(WIDTH-18){i_branch_offset[15]}}, i_branch_offset, 2'b00};
    src = exc ? PCSRC_EXC : i_eret ? PCSRC_ERET : i_jr ? PCSRC_JR :
          i_jump ? PCSRC_J : i_branch_taken ? PCSRC_BR : PCSRC_SEQ;
    next_pc = src == PCSRC_EXC ? EXC_VECTOR : src == PCSRC_ERET ? epc_q :
              src == PCSRC_JR ? i_jr_target : src == PCSRC_J ? j_tgt :
              src == PCSRC_BR ? br_tgt : o_pc_plus4;
    pc_d = hold ? pc_q : next_pc[WIDTH-1:2];
    epc_d = exc ? o_pc : epc_q;
    replace = adv & i_call & i_ret & i_jr;
    push = adv & i_call & (i_jump | i_jr) & !(i_ret & i_jr);
    pop = adv & i_ret & i_jr & !i_call;
    mismatch_d = hold ? mismatch_q : pop & (o_ras_empty | (o_ras_top != i_jr_target));
    misaligned_d = hold ? misaligned_q : jr_bad & !i_exception;
  end
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      pc_q <= RESET_VECTOR[WIDTH-1:2];
      epc_q <= '0;
      mismatch_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      epc_q <= epc_d;
      mismatch_q <= mismatch_d;
      misaligned_q <= misaligned_d;
    end
  end
  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .i_clk(i_clk),
    .i_arstn(i_arstn),
    .i_push(push),
    .i_pop(pop),
    .i_replace(replace),
    .i_data(o_pc_plus4),
    .o_top(o_ras_top),
    .o_empty(o_ras_empty),
    .o_full(o_ras_full)
  );
  assign o_epc = epc_q;
  assign o_ras_mismatch = mismatch_q;
  assign o_misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a behavioural model feeding an expected-value scoreboard.
module tb_pc_sequencer;
  localparam logic [31:0] EXC = 32'h8000_0180;
  logic clk = 0, arstn = 0;
  logic stall, br, j, jr, call, ret, ex, eret;
  logic [15:0] off;
  logic [25:0] idx;
  logic [31:0] tgt;
  logic [31:0] o_pc, o_pc_plus4, o_epc, o_ras_top;
  logic o_ras_empty, o_ras_full, o_ras_mismatch, o_misaligned;
  typedef struct {
    logic [31:0] pc, epc, top;
    logic e, f, mm, ma;
  } exp_t;
  exp_t sbq[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc, m_epc;
  logic m_mm, m_ma;
  int nerr = 0, nchk = 0;

  pc_sequencer dut (
    .i_clk(clk), .i_arstn(arstn), .i_stall(stall), .i_branch_taken(br),
    .i_branch_offset(off), .i_jump(j), .i_jump_index(idx), .i_jr(jr),
    .i_jr_target(tgt), .i_call(call), .i_ret(ret), .i_exception(ex),
    .i_eret(eret), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_epc(o_epc),
    .o_ras_top(o_ras_top), .o_ras_empty(o_ras_empty), .o_ras_full(o_ras_full),
    .o_ras_mismatch(o_ras_mismatch), .o_misaligned(o_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clr();
    {stall, br, j, jr, call, ret, ex, eret} = '0;
    off = '0;
    idx = '0;
    tgt = '0;
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_epc = 0;
    m_mm = 0;
    m_ma = 0;
    m_ras.delete();
  endtask

  task automatic tick(input string tag);
    exp_t e;
    logic bad;
    logic [31:0] p4;
    bad = jr & (tgt[1:0] != 2'b00);
    p4 = m_pc + 4;
    if (ex | bad) begin
      m_epc = m_pc;
      m_pc = EXC;
      m_ma = bad & !ex;
      m_mm = 0;
    end else if (!stall) begin
      m_mm = 0;
      if (call & (j | jr)) begin
        if (ret & jr && m_ras.size() > 0) m_ras[m_ras.size()-1] = p4;
        else begin
          m_ras.push_back(p4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end else if (ret & jr) begin
        if (m_ras.size() == 0) m_mm = 1;
        else begin
          m_mm = m_ras[m_ras.size()-1] != tgt;
          void'(m_ras.pop_back());
        end
      end
      m_ma = 0;
      m_pc = eret ? m_epc : jr ? tgt : j ? {p4[31:28], idx, 2'b00} :
             br ? p4 + {{14{off[15]}}, off, 2'b00} : p4;
    end
    e.pc = m_pc;
    e.epc = m_epc;
    e.top = m_ras.size() > 0 ? m_ras[m_ras.size()-1] : 32'h0;
    e.e = m_ras.size() == 0;
    e.f = m_ras.size() == 4;
    e.mm = m_mm;
    e.ma = m_ma;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".pc"}, o_pc, e.pc);
    chk({tag, ".pc4"}, o_pc_plus4, e.pc + 32'd4);
    chk({tag, ".epc"}, o_epc, e.epc);
    chk({tag, ".top"}, o_ras_top, e.top);
    chk({tag, ".empty"}, {31'b0, o_ras_empty}, {31'b0, e.e});
    chk({tag, ".full"}, {31'b0, o_ras_full}, {31'b0, e.f});
    chk({tag, ".mism"}, {31'b0, o_ras_mismatch}, {31'b0, e.mm});
    chk({tag, ".misal"}, {31'b0, o_misaligned}, {31'b0, e.ma});
  endtask

  initial begin
    clr();
    model_reset();
    #12;
    chk("rst.pc", o_pc, 32'h0);
    chk("rst.epc", o_epc, 32'h0);
    chk("rst.empty", {31'b0, o_ras_empty}, 32'h1);
    @(negedge clk);
    arstn = 1;
    for (int i = 1; i <= 3; i++) begin
      tick("idle");
      chk("idle.plan", o_pc, 32'(4 * i));
    end
    tick("idle");
    br = 1; off = 16'hFFFC; tick("br_back");
    chk("br_back.plan", o_pc, 32'h04);
    off = 16'h0003; tick("br_fwd");
    chk("br_fwd.plan", o_pc, 32'h14);
    clr(); jr = 1; tgt = 32'h0040_0000; tick("jr");
    clr(); j = 1; call = 1; idx = 26'h0100000; tick("jal");
    chk("jal.plan", o_ras_top, 32'h0040_0004);
    clr(); jr = 1; ret = 1; tgt = 32'h0040_0004; tick("ret");
    chk("ret.plan", o_pc, 32'h0040_0004);
    chk("ret.empty", {31'b0, o_ras_empty}, 32'h1);
    for (int i = 1; i <= 5; i++) begin
      clr(); j = 1; call = 1; idx = 26'h0100000 + 26'(4 * i); tick("push");
    end
    chk("push.full", {31'b0, o_ras_full}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      clr(); jr = 1; ret = 1; tgt = m_ras[m_ras.size()-1]; tick("pop");
    end
    chk("pop.empty", {31'b0, o_ras_empty}, 32'h1);
    clr(); jr = 1; ret = 1; tgt = 32'h0000_0200; tick("pop_empty");
    chk("pop_empty.plan", {31'b0, o_ras_mismatch}, 32'h1);
    clr(); stall = 1; tick("flag_hold");
    clr(); j = 1; call = 1; idx = 26'h40; tick("push1");
    clr(); jr = 1; ret = 1; tgt = 32'h0000_0444; tick("pop_wrong");
    clr(); j = 1; call = 1; idx = 26'h50; tick("push2");
    clr(); jr = 1; call = 1; ret = 1; tgt = 32'h0000_0300; tick("replace");
    clr(); jr = 1; call = 1; ret = 1; tgt = 32'hFFFF_FFFC; tick("replace2");
    clr(); tick("wrap");
    chk("wrap.plan", o_pc, 32'h0);
    clr(); jr = 1; tgt = 32'h20; tick("to20");
    clr(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      br = 1; off = 16'h0010; tick("stall");
      chk("stall.plan", o_pc, 32'h20);
    end
    ex = 1; tick("exc_stall");
    chk("exc.plan", o_pc, EXC);
    chk("exc.epc", o_epc, 32'h20);
    clr(); eret = 1; tick("eret");
    chk("eret.plan", o_pc, 32'h20);
    clr(); jr = 1; tgt = 32'h30; tick("to30");
    clr(); jr = 1; ret = 1; tgt = 32'h0000_0102; tick("jr_misal");
    chk("misal.plan", {31'b0, o_misaligned}, 32'h1);
    chk("misal.epc", o_epc, 32'h30);
    clr(); tick("misal_clear");
    clr(); stall = 1; tick("pre_rst");
    #2;
    arstn = 0;
    #1;
    model_reset();
    chk("arst.pc", o_pc, 32'h0);
    chk("arst.epc", o_epc, 32'h0);
    chk("arst.empty", {31'b0, o_ras_empty}, 32'h1);
    @(negedge clk);
    arstn = 1;
    clr(); tick("post_rst");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
